rr_txn_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-outstanding-transaction resource among N requesters, such as a refill port or a shared write port.
- It picks one requester by rotating priority and presents a one-hot grant plus an encoded id.
- It holds the grant through a valid/ready handshake and then through a busy phase until the resource signals completion.
- It sits between the requesting units and the shared resource, which consumes the one-hot and encoded forms directly.

---
 rtl/rr_txn_arbiter_pkg.sv | 8 +
 rtl/rr_txn_arbiter_if.sv | 22 ++
 rtl/rr_txn_arbiter_pick.sv | 24 ++
 rtl/rr_txn_arbiter.sv | 75 +++++++
 tb/tb_rr_txn_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/rr_txn_arbiter_pkg.sv
// rr_txn_arbiter_pkg: shared FSM state encoding (ARB_IDLE=0, ARB_GRANT=1, ARB_BUSY=2) for the round-robin arbiter
package rr_txn_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_txn_arbiter_if.sv
// rr_txn_arbiter_if: arbiter bus; master drives req/res_ready/done, slave (arbiter) drives grant/grant_id/grant_valid/busy/ptr
interface rr_txn_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic           res_ready;
  logic           done;
  logic           busy;
  logic [IDW-1:0] ptr;
  modport master (
    output req, res_ready, done,
    input  grant, grant_id, grant_valid, busy, ptr
  );
  modport slave (
    input  req, res_ready, done,
    output grant, grant_id, grant_valid, busy, ptr
  );
endinterface

// File: rtl/rr_txn_arbiter_pick.sv
// rr_pick: combinational rotating-priority pick; in req/ptr, out onehot winner, its binary idx and any-request flag
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);
  logic [N-1:0] upper;
  logic [N-1:0] masked;
  logic [N-1:0] sel;
  always_comb begin
    for (int i = 0; i < N; i++) upper[i] = (i >= int'(ptr));
    masked = req & upper;
    sel    = |masked ? masked : req;
    onehot = sel & (~sel + 1'b1);
    idx    = '0;
    for (int i = 0; i < N; i++) if (onehot[i]) idx = IDW'(i);
    any    = |req;
  end
endmodule

// File: rtl/rr_txn_arbiter.sv
// rr_txn_arbiter: round-robin single-outstanding-transaction arbiter; ports clk, resetn (async low), bus (slave modport)
import rr_txn_arbiter_pkg::*;
module rr_txn_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            resetn,
  rr_txn_arbiter_if.slave bus
);
  arb_state_e     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   pick_onehot;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           held;
  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );
  assign held = bus.req[id_q];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end
  always_comb begin
    state_d = ARB_IDLE;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        state_d = pick_any ? ARB_GRANT : ARB_IDLE;
        grant_d = pick_onehot;
        id_d    = pick_idx;
      end
      ARB_GRANT: begin
        state_d = !held ? ARB_IDLE : bus.res_ready ? ARB_BUSY : ARB_GRANT;
        grant_d = held ? grant_q : '0;
        id_d    = held ? id_q : '0;
      end
      ARB_BUSY: begin
        state_d = bus.done ? ARB_IDLE : ARB_BUSY;
        grant_d = bus.done ? '0 : grant_q;
        id_d    = bus.done ? '0 : id_q;
        ptr_d   = !bus.done ? ptr_q : (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
      end
      default: begin
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end
  always_comb begin
    bus.grant       = grant_q;
    bus.grant_id    = id_q;
    bus.ptr         = ptr_q;
    bus.grant_valid = (state_q == ARB_GRANT);
    bus.busy        = (state_q == ARB_BUSY);
  end
endmodule

// File: tb/tb_rr_txn_arbiter.sv
// tb_rr_txn_arbiter: directed self-checking bench for rr_txn_arbiter
module tb_rr_txn_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  rr_txn_arbiter_if #(.N(4), .IDW(2)) bus ();
  rr_txn_arbiter #(.N(4), .IDW(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic gv, input logic bsy, input logic [3:0] g,
                         input logic [1:0] id, input logic [1:0] p);
    check({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(gv));
    check({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".grant_id"}, 32'(bus.grant_id), 32'(id));
    check({tag, ".ptr"}, 32'(bus.ptr), 32'(p));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.req = 4'b0000;
    bus.res_ready = 1'b0;
    bus.done = 1'b0;
    tick();
    tick();
    chk_out("reset", 0, 0, 4'b0000, 0, 0);
    resetn = 1'b1;
    tick();
    chk_out("idle_no_req", 0, 0, 4'b0000, 0, 0);
    bus.req = 4'b1010;
    tick();
    chk_out("basic_grant1", 1, 0, 4'b0010, 1, 0);
    bus.done = 1'b1;
    tick();
    chk_out("done_in_grant_ignored", 1, 0, 4'b0010, 1, 0);
    bus.done = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    chk_out("basic_busy1", 0, 1, 4'b0010, 1, 0);
    bus.res_ready = 1'b0;
    bus.done = 1'b1;
    tick();
    chk_out("basic_done1", 0, 0, 4'b0000, 0, 2);
    bus.done = 1'b0;
    tick();
    chk_out("ptr_grant3", 1, 0, 4'b1000, 3, 2);
    bus.res_ready = 1'b1;
    tick();
    chk_out("busy3", 0, 1, 4'b1000, 3, 2);
    bus.res_ready = 1'b0;
    bus.done = 1'b1;
    tick();
    chk_out("wrap_ptr0", 0, 0, 4'b0000, 0, 0);
    bus.done = 1'b0;
    bus.req = 4'b0011;
    tick();
    chk_out("wrap_grant0", 1, 0, 4'b0001, 0, 0);
    bus.req = 4'b0100;
    tick();
    chk_out("withdraw0", 0, 0, 4'b0000, 0, 0);
    tick();
    chk_out("grant2", 1, 0, 4'b0100, 2, 0);
    bus.res_ready = 1'b1;
    tick();
    chk_out("busy2", 0, 1, 4'b0100, 2, 0);
    bus.res_ready = 1'b0;
    bus.done = 1'b1;
    tick();
    chk_out("ptr3", 0, 0, 4'b0000, 0, 3);
    bus.done = 1'b0;
    bus.req = 4'b0011;
    tick();
    chk_out("wrap_from3", 1, 0, 4'b0001, 0, 3);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.done = 1'b1;
    tick();
    chk_out("ptr1", 0, 0, 4'b0000, 0, 1);
    bus.done = 1'b0;
    bus.req = 4'b0010;
    tick();
    chk_out("grant1_pre_withdraw", 1, 0, 4'b0010, 1, 1);
    bus.req = 4'b0000;
    bus.res_ready = 1'b1;
    tick();
    chk_out("withdraw_wins", 0, 0, 4'b0000, 0, 1);
    bus.res_ready = 1'b0;
    bus.done = 1'b1;
    tick();
    chk_out("done_in_idle", 0, 0, 4'b0000, 0, 1);
    bus.done = 1'b0;
    bus.req = 4'b1000;
    tick();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.done = 1'b1;
    tick();
    chk_out("fair_setup", 0, 0, 4'b0000, 0, 0);
    bus.done = 1'b0;
    bus.req = 4'b1111;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] id;
      logic [3:0] oh;
      id = 2'(k % 4);
      oh = 4'b0001 << id;
      tick();
      chk_out($sformatf("fair%0d_grant", k), 1, 0, oh, id, id);
      tick();
      chk_out($sformatf("fair%0d_busy_a", k), 0, 1, oh, id, id);
      bus.req = 4'b0000;
      tick();
      chk_out($sformatf("fair%0d_busy_b", k), 0, 1, oh, id, id);
      bus.req = 4'b1111;
      tick();
      chk_out($sformatf("fair%0d_busy_c", k), 0, 1, oh, id, id);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      chk_out($sformatf("fair%0d_done", k), 0, 0, 4'b0000, 0, id + 2'd1);
    end
    bus.req = 4'b0100;
    tick();
    chk_out("rst_pre_grant", 1, 0, 4'b0100, 2, 0);
    tick();
    chk_out("rst_pre_busy", 0, 1, 4'b0100, 2, 0);
    bus.req = 4'b1011;
    #2;
    resetn = 1'b0;
    #1;
    chk_out("async_reset", 0, 0, 4'b0000, 0, 0);
    bus.res_ready = 1'b0;
    tick();
    chk_out("reset_held", 0, 0, 4'b0000, 0, 0);
    resetn = 1'b1;
    bus.req = 4'b0100;
    tick();
    chk_out("post_reset_grant", 1, 0, 4'b0100, 2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
